// File: rtl/writeback_stage.sv
// MEM/WB stage: retires ALU/link results 1 cycle after acceptance, loads 1 cycle after dmem_rvalid.
// Backpressure: mem_ready is low while a load waits for its data; no new instruction is taken then.
module writeback_stage #(
  parameter int XLEN         = 32,
  parameter int NREG_BITS    = 6,
  parameter int ZERO_REG_IDX = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [NREG_BITS-1:0] mem_rd,
  input  logic [1:0]           mem_wb_sel,
  input  logic [XLEN-1:0]      mem_alu_result,
  input  logic [XLEN-1:0]      mem_pc_plus4,
  input  logic [1:0]           mem_load_size,
  input  logic                 mem_load_unsigned,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic [NREG_BITS-1:0] WB_rd,
  output logic [XLEN-1:0]      WB_data,
  output logic                 wb_valid,
  output logic [31:0]          wb_retire_count
);

  localparam logic [NREG_BITS-1:0] NO_WRITE = NREG_BITS'(ZERO_REG_IDX);

  typedef enum logic {S_IDLE, S_WAIT_LOAD} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_accept;
  logic                  w_is_load;
  logic                  w_load_done;
  logic                  w_retire;
  logic [NREG_BITS-1:0]  r_ld_rd;
  logic [1:0]            r_ld_addr;
  logic [1:0]            r_ld_size;
  logic                  r_ld_uns;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_ld_data;
  logic [XLEN-1:0]       w_alu_pc;
  logic [NREG_BITS-1:0]  r_wb_rd;
  logic [XLEN-1:0]       r_wb_data;
  logic                  r_wb_vld;
  logic [31:0]           r_retire_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  assign w_is_load = (mem_wb_sel == 2'b01);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (mem_valid && w_is_load) w_next_state = S_WAIT_LOAD;
      S_WAIT_LOAD: if (dmem_rvalid)            w_next_state = S_IDLE;
      default:                                 w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ready   = (r_state == S_IDLE);
    w_accept    = (r_state == S_IDLE) && mem_valid;
    w_load_done = (r_state == S_WAIT_LOAD) && dmem_rvalid;
  end

  // Halfword ignores a[0]: misaligned halves silently read the containing half.
  always_comb begin
    case (r_ld_addr)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_ld_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_ld_size)
      2'b00:   w_ld_data = {{(XLEN-8){~r_ld_uns & w_byte[7]}}, w_byte};
      2'b01:   w_ld_data = {{(XLEN-16){~r_ld_uns & w_half[15]}}, w_half};
      default: w_ld_data = dmem_rdata;
    endcase
  end

  assign w_alu_pc = (mem_wb_sel == 2'b10) ? mem_pc_plus4 : mem_alu_result;
  assign w_retire = (w_accept && !w_is_load) || w_load_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_rd   <= NO_WRITE;
      r_ld_addr <= 2'b00;
      r_ld_size <= 2'b00;
      r_ld_uns  <= 1'b0;
    end else if (w_accept && w_is_load) begin
      r_ld_rd   <= mem_rd;
      r_ld_addr <= mem_alu_result[1:0];
      r_ld_size <= mem_load_size;
      r_ld_uns  <= mem_load_unsigned;
    end
  end

  // WB_data holds between writes; only rd/valid fall back to "no write".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_rd   <= NO_WRITE;
      r_wb_data <= '0;
      r_wb_vld  <= 1'b0;
    end else if (w_load_done) begin
      r_wb_rd   <= r_ld_rd;
      r_wb_data <= w_ld_data;
      r_wb_vld  <= 1'b1;
    end else if (w_accept && !w_is_load) begin
      r_wb_rd   <= mem_rd;
      r_wb_data <= w_alu_pc;
      r_wb_vld  <= 1'b1;
    end else begin
      r_wb_rd   <= NO_WRITE;
      r_wb_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_retire_count <= 32'd0;
    else if (w_retire) r_retire_count <= r_retire_count + 32'd1;
  end

  assign WB_rd           = r_wb_rd;
  assign WB_data         = r_wb_data;
  assign wb_valid        = r_wb_vld;
  assign wb_retire_count = r_retire_count;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage against a load-queue reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [5:0]  mem_rd = '0;
  logic [1:0]  mem_wb_sel = '0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_pc_plus4 = '0;
  logic [1:0]  mem_load_size = '0;
  logic        mem_load_unsigned = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [5:0]  WB_rd;
  logic [31:0] WB_data;
  logic        wb_valid;
  logic [31:0] wb_retire_count;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel),
    .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .mem_load_size(mem_load_size), .mem_load_unsigned(mem_load_unsigned),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .WB_rd(WB_rd), .WB_data(WB_data), .wb_valid(wb_valid),
    .wb_retire_count(wb_retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] rd;
    logic [1:0] a;
    logic [1:0] sz;
    logic       un;
  } ld_t;

  ld_t         pend[$];
  logic [5:0]  e_rd;
  logic [31:0] e_data;
  logic        e_vld;
  logic [31:0] e_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Byte/half/word extraction expressed as shift-and-mask arithmetic.
  function automatic logic [31:0] ld_ref(input logic [31:0] w, input logic [1:0] a,
                                         input logic [1:0] sz, input logic un);
    int nb, off;
    logic [31:0] m, v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = (sz == 2'd0) ? int'(a) : (sz == 2'd1) ? int'(a & 2'd2) : 0;
    m   = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v   = (w >> (8 * off)) & m;
    if (!un && (((v >> (8 * nb - 1)) & 32'd1) == 32'd1)) v = v | ~m;
    return v;
  endfunction

  task automatic model_reset();
    pend.delete();
    e_rd = '0; e_data = '0; e_vld = 1'b0; e_cnt = '0;
  endtask

  // One cycle: check ready, drive at negedge, predict, then check registered outputs.
  task automatic cyc(input logic v, input logic [5:0] rd, input logic [1:0] sel,
                     input logic [31:0] alu, input logic [31:0] pc4,
                     input logic [1:0] sz, input logic un,
                     input logic rv, input logic [31:0] rdata);
    ld_t l;
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, pend.size() == 0});
    mem_valid = v; mem_rd = rd; mem_wb_sel = sel; mem_alu_result = alu;
    mem_pc_plus4 = pc4; mem_load_size = sz; mem_load_unsigned = un;
    dmem_rvalid = rv; dmem_rdata = rdata;
    e_vld = 1'b0; e_rd = '0;
    if (pend.size() != 0) begin
      if (rv) begin
        l = pend.pop_front();
        e_vld = 1'b1; e_rd = l.rd; e_data = ld_ref(rdata, l.a, l.sz, l.un);
      end
    end else if (v && sel == 2'b01) begin
      l.rd = rd; l.a = alu[1:0]; l.sz = sz; l.un = un;
      pend.push_back(l);
    end else if (v) begin
      e_vld = 1'b1; e_rd = rd; e_data = (sel == 2'b10) ? pc4 : alu;
    end
    if (e_vld) e_cnt = e_cnt + 32'd1;
    @(negedge clk);
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_vld});
    chk("WB_rd", {26'd0, WB_rd}, {26'd0, e_rd});
    chk("WB_data", WB_data, e_data);
    chk("retire_count", wb_retire_count, e_cnt);
  endtask

  task automatic idle(input logic rv);
    cyc(1'b0, 6'd0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, rv, 32'hDEAD_BEEF);
  endtask

  task automatic alu_op(input logic [5:0] rd, input logic [31:0] val);
    cyc(1'b1, rd, 2'b00, val, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic load(input logic [5:0] rd, input logic [31:0] addr, input logic [1:0] sz,
                      input logic un, input int lat, input logic [31:0] rdata);
    cyc(1'b1, rd, 2'b01, addr, 32'h0, sz, un, 1'b0, 32'h0);
    for (int i = 1; i < lat; i++) idle(1'b0);
    idle_rv(rdata);
  endtask

  task automatic idle_rv(input logic [31:0] rdata);
    cyc(1'b0, 6'd0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, rdata);
  endtask

  initial begin
    logic [31:0] c0;
    model_reset();
    #1;
    chk("rst_WB_rd", {26'd0, WB_rd}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_count", wb_retire_count, 32'd0);
    chk("rst_WB_data", WB_data, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Reset while waiting for load data
    alu_op(6'd3, 32'h55);
    cyc(1'b1, 6'd4, 2'b01, 32'h100, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);
    idle(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_WB_rd", {26'd0, WB_rd}, 32'd0);
    chk("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("mid_rst_count", wb_retire_count, 32'd0);
    chk("mid_rst_ready", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle_rv(32'h1234_5678);
    chk("late_rvalid", {31'd0, wb_valid}, 32'd0);

    // ALU back-to-back
    alu_op(6'd5, 32'h11);
    chk("b2b0", {26'd0, WB_rd, 31'd0} >> 31, 32'd5);
    alu_op(6'd6, 32'h22);
    chk("b2b1_data", WB_data, 32'h22);
    alu_op(6'd7, 32'h33);
    chk("b2b2_data", WB_data, 32'h33);
    chk("b2b_count", wb_retire_count, 32'd3);

    // Loads with alignment/extension variants
    load(6'd9, 32'h0000_1003, 2'b00, 1'b0, 3, 32'h80FF_1234);
    chk("lb_rd", {26'd0, WB_rd}, 32'd9);
    chk("lb_data", WB_data, 32'hFFFF_FF80);
    load(6'd10, 32'h0000_2002, 2'b01, 1'b1, 1, 32'hBEEF_0001);
    chk("lhu_data", WB_data, 32'h0000_BEEF);
    load(6'd11, 32'h0000_2001, 2'b01, 1'b0, 2, 32'h0000_8001);
    chk("lh_data", WB_data, 32'hFFFF_8001);
    load(6'd12, 32'h0000_3003, 2'b10, 1'b0, 1, 32'hCAFE_F00D);
    chk("lw_data", WB_data, 32'hCAFE_F00D);
    load(6'd0, 32'h0000_0000, 2'b10, 1'b0, 4, 32'h0BAD_0BAD);
    chk("ld_rd0_vld", {31'd0, wb_valid}, 32'd1);

    // Link, rd 0, stray rvalid
    cyc(1'b1, 6'd1, 2'b10, 32'hAAAA_AAAA, 32'h104, 2'b00, 1'b0, 1'b0, 32'h0);
    chk("link_data", WB_data, 32'h104);
    c0 = wb_retire_count;
    alu_op(6'd0, 32'h77);
    chk("rd0_rd", {26'd0, WB_rd}, 32'd0);
    chk("rd0_count", wb_retire_count, c0 + 32'd1);
    idle_rv(32'hFFFF_FFFF);
    chk("stray_rvalid", {31'd0, wb_valid}, 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic rv;
      rv = (pend.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      cyc(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
          $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          rv, $urandom);
    end
    while (pend.size() != 0) idle_rv($urandom);

    // Counter wrap
    force dut.r_retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_count;
    chk("preload", wb_retire_count, 32'hFFFF_FFFF);
    e_cnt = 32'hFFFF_FFFF;
    alu_op(6'd2, 32'h99);
    chk("wrap", wb_retire_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline stage that sits directly upstream of the 64-entry register file.
- Captures the retiring instruction from the memory stage and, for loads, waits for the data-memory response. It then aligns and sign- or zero-extends the load data.
- Selects the final result (ALU, load, PC+4) and drives WB_data/WB_rd into the register file write port.
- Also keeps a retired-instruction count for performance monitoring.

Parameters:
- XLEN, 32, datapath width.
- NREG_BITS, 6, register index width (64 architectural/temporary registers).
- ZERO_REG_IDX, 0, index meaning "no write". It must equal `ZERO_REG in sys_defs.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_valid  in  1  memory stage presents an instruction
- mem_ready  out  1  stage accepts the instruction this cycle
- mem_rd  in  6  destination register
- mem_wb_sel  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU
- mem_alu_result  in  32  ALU result / effective address
- mem_pc_plus4  in  32  link value
- mem_load_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_load_unsigned  in  1  zero-extend when 1
- dmem_rvalid  in  1  load data valid (single-cycle pulse)
- dmem_rdata  in  32  raw word read from data memory
- WB_rd  out  6  register file write index; ZERO_REG_IDX means no write
- WB_data  out  32  register file write data
- wb_valid  out  1  an instruction retired this cycle
- wb_retire_count  out  32  retired-instruction counter

Behaviour:
- All outputs are registered except mem_ready.
- Reset (async, any cycle including mid-load):
  - state=IDLE, WB_rd=0, WB_data=0, wb_valid=0, wb_retire_count=0.
  - Any pending load is discarded and a late dmem_rvalid is ignored.
- FSM states: IDLE, WAIT_LOAD.
- mem_ready = (state==IDLE). It is combinational and depends on no other input.
- IDLE, mem_valid=1, wb_sel!=01:
  - Next edge: WB_rd=mem_rd, WB_data = ALU result or PC+4, wb_valid=1.
  - Latency is 1 cycle from acceptance.
- IDLE, mem_valid=1, wb_sel=01 (load):
  - Latch rd, address bits [1:0], size and unsigned.
  - Next edge: state=WAIT_LOAD, WB_rd=0, wb_valid=0.
- IDLE, mem_valid=0: next edge WB_rd=0, wb_valid=0. WB_data holds its last value.
- WAIT_LOAD, dmem_rvalid=0: WB_rd=0, wb_valid=0, stay in WAIT_LOAD. No timeout.
- WAIT_LOAD, dmem_rvalid=1:
  - Next edge: WB_rd=latched rd, WB_data=aligned data, wb_valid=1, state=IDLE.
  - Load result appears 1 cycle after the rvalid cycle.
  - A new instruction cannot be accepted in the rvalid cycle; mem_ready rises the following cycle.
- dmem_rvalid in IDLE is ignored.
- Load alignment, with a = latched address bits [1:0]:
  - Byte: take dmem_rdata[8a+7:8a].
  - Half: take the halfword selected by a[1]; a[0] is ignored, with no misalignment trap.
  - Word: take the full word; a is ignored.
  - Extension: sign-extend from the top selected bit unless unsigned=1, then zero-extend.
- Instruction with mem_rd=0:
  - Retires normally: wb_valid=1, the counter increments, and WB_rd=0 so the register file ignores it.
  - A load to rd 0 still waits for rvalid.
- wb_retire_count increments by 1 on each wb_valid cycle and wraps 0xFFFFFFFF -> 0.

Test Plan:
- Reset mid-operation: assert rst while in WAIT_LOAD -> WB_rd=0, wb_valid=0, count=0, mem_ready=1. An rvalid pulse after reset produces no write.
- ALU back-to-back: three ALU instructions (rd=5,6,7; results 0x11,0x22,0x33) on consecutive cycles -> each appears exactly 1 cycle later on WB_rd/WB_data with wb_valid=1; count reaches 3.
- Load with 3-cycle memory latency, lb signed, address low bits 2'b11, dmem_rdata=0x80FF_1234, rd=9:
  - mem_ready=0 for the wait cycles.
  - The cycle after rvalid: WB_rd=9, WB_data=0xFFFF_FF80.
- Load alignment variants:
  - lhu, address low bits 2'b10, data 0xBEEF_0001 -> 0x0000_BEEF.
  - lh, address low bits 2'b01, data 0x0000_8001 -> 0xFFFF_8001 (a[0] ignored).
  - lw -> raw word.
- Link and zero-register handling:
  - wb_sel=10, pc_plus4=0x104, rd=1 -> WB_data=0x104.
  - ALU instruction with rd=0 -> WB_rd=0, wb_valid=1, count increments.
  - Stray rvalid in IDLE -> no retirement.
- Counter wrap: force count to 0xFFFF_FFFF (retire 2^32-1 instructions, or preload via hierarchical force), then retire one instruction -> count=0.
